// File: rtl/ring_step_decoder.sv
// ring_step_decoder
//   Consumer end of the one-hot T-state ring timer. It combines the timer step
//   and the instruction opcode into the 16-bit datapath control word. It also
//   drives the timer restart/stop lines back to end instructions early, halt
//   the machine and recover from corrupted ring states, and it keeps retire and
//   fault counters for debug.
//
//   Optional feature macro: SEQ_SINGLE_STEP_EN (adds step_mode / step_go).
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   t_state[7:0]    one-hot timer step, bit0=T1 .. bit7=T8, 0 while stopped
//   ir_opcode[3:0]  upper nibble of the instruction register
//   carry_flag      ALU carry flag
//   zero_flag       ALU zero flag
//   step_mode       (SEQ_SINGLE_STEP_EN) pause after every retired instruction
//   step_go         (SEQ_SINGLE_STEP_EN) release a paused machine for one instruction
//   ctrl[15:0]      HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI (bit 15..0)
//   ring_restart    combinational; timer reloads T1 on the next edge
//   ring_stop       registered timer stop
//   halted          sticky HLT indication
//   fault           sticky illegal-ring-state indication
//   fault_cnt       saturating count of fault cycles
//   instr_cnt       wrapping count of retired instructions
module ring_step_decoder #(
    parameter int CNT_W   = 16,
    parameter int FAULT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         t_state,
    input  logic [3:0]         ir_opcode,
    input  logic               carry_flag,
    input  logic               zero_flag,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step_mode,
    input  logic               step_go,
`endif
    output logic [15:0]        ctrl,
    output logic               ring_restart,
    output logic               ring_stop,
    output logic               halted,
    output logic               fault,
    output logic [FAULT_W-1:0] fault_cnt,
    output logic [CNT_W-1:0]   instr_cnt
);

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    function automatic logic [FAULT_W-1:0] sat_inc(input logic [FAULT_W-1:0] v);
        return (&v) ? v : v + FAULT_W'(1);
    endfunction

    logic [3:0] op_q;
    logic       one_hot;
    logic       legal_step;
    logic       idle;
    logic       last;
    logic       retire;
    logic       fault_ev;
    logic       hlt_dec;
    logic       latch_op;

    assign one_hot    = (t_state != 8'h00) && ((t_state & (t_state - 8'h01)) == 8'h00);
    // T6..T8 can only be reached if a restart was missed.
    assign legal_step = one_hot && (t_state[7:5] == 3'b000);

`ifdef SEQ_SINGLE_STEP_EN
    logic park_q;
    // While parked, ignore the ring until the timer has been released and
    // shows its first step again.
    assign idle = park_q && (ring_stop || (t_state == 8'h00));
`else
    assign idle = 1'b0;
`endif

    always_comb begin
        ctrl         = 16'h0000;
        ring_restart = 1'b0;
        last         = 1'b0;
        retire       = 1'b0;
        fault_ev     = 1'b0;
        hlt_dec      = 1'b0;
        latch_op     = 1'b0;
        if (reset) begin
            ring_restart = 1'b1;
        end else if (halted || idle) begin
            ctrl = 16'h0000;
        end else if (!legal_step) begin
            ring_restart = 1'b1;
            fault_ev     = 1'b1;
        end else begin
            case (t_state)
                8'h01: ctrl = C_CO | C_MI;
                8'h02: ctrl = C_RO | C_II | C_CE;
                8'h04: begin
                    latch_op = 1'b1;
                    last     = 1'b1;
                    case (ir_opcode)
                        4'd0, 4'd1, 4'd2, 4'd3: begin
                            ctrl = C_IO | C_MI;
                            last = 1'b0;
                        end
                        4'd4:    ctrl = C_IO | C_AI;
                        4'd5:    ctrl = C_IO | C_J;
                        4'd6:    ctrl = carry_flag ? (C_IO | C_J) : 16'h0000;
                        4'd7:    ctrl = zero_flag ? (C_IO | C_J) : 16'h0000;
                        4'd14:   ctrl = C_AO | C_OI;
                        4'd15: begin
                            ctrl    = C_HLT;
                            hlt_dec = 1'b1;
                        end
                        default: ctrl = 16'h0000;
                    endcase
                end
                8'h08: begin
                    case (op_q)
                        4'd0: begin ctrl = C_RO | C_AI; last = 1'b1; end
                        4'd1, 4'd2: ctrl = C_RO | C_BI;
                        4'd3: begin ctrl = C_AO | C_RI; last = 1'b1; end
                        // No T4 for this opcode: pull the ring back without retiring.
                        default: ring_restart = 1'b1;
                    endcase
                end
                8'h10: begin
                    case (op_q)
                        4'd1: begin ctrl = C_EO | C_AI | C_FI; last = 1'b1; end
                        4'd2: begin ctrl = C_EO | C_AI | C_FI | C_SU; last = 1'b1; end
                        default: ring_restart = 1'b1;
                    endcase
                end
                default: ring_restart = 1'b1;
            endcase
            if (last) begin
                ring_restart = 1'b1;
                retire       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= 4'h0;
            ring_stop <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            fault_cnt <= '0;
            instr_cnt <= '0;
`ifdef SEQ_SINGLE_STEP_EN
            park_q    <= 1'b0;
`endif
        end else begin
            if (latch_op) op_q <= ir_opcode;
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
            if (fault_ev) begin
                fault     <= 1'b1;
                fault_cnt <= sat_inc(fault_cnt);
            end
`ifdef SEQ_SINGLE_STEP_EN
            if (park_q && !ring_stop && (t_state != 8'h00) && !halted) park_q <= 1'b0;
            if (retire && step_mode && !hlt_dec) begin
                ring_stop <= 1'b1;
                park_q    <= 1'b1;
            end else if (step_go && ring_stop && park_q && !halted) begin
                ring_stop <= 1'b0;
            end
`endif
            if (hlt_dec) begin
                halted    <= 1'b1;
                ring_stop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ring_step_decoder.sv
// tb_ring_step_decoder
//   Drives ring_step_decoder from a behavioural ring timer (restart reloads T1,
//   stop parks it at 0) with optional illegal-state injection. A reference
//   model built from per-opcode micro-step tables predicts every output on
//   every cycle; directed sections pin the model with literal control words.
module tb_ring_step_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  t_state;
    logic [3:0]  ir_opcode = 4'd4;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic [15:0] ctrl;
    logic        ring_restart, ring_stop, halted, fault;
    logic [3:0]  fault_cnt;
    logic [15:0] instr_cnt;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step_mode = 1'b0;
    logic        step_go = 1'b0;
`endif

    logic [7:0]  tmr = 8'h00;
    logic        force_en = 1'b0;
    logic [7:0]  force_val = 8'h00;
    assign t_state = force_en ? force_val : tmr;

    ring_step_decoder #(.CNT_W(16), .FAULT_W(4)) dut (
        .clk(clk), .reset(reset), .t_state(t_state), .ir_opcode(ir_opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode(step_mode), .step_go(step_go),
`endif
        .ctrl(ctrl), .ring_restart(ring_restart), .ring_stop(ring_stop),
        .halted(halted), .fault(fault), .fault_cnt(fault_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Ring timer behaviour seen by the decoder.
    always @(posedge clk) begin
        if (ring_stop === 1'b1)         tmr <= 8'h00;
        else if (ring_restart === 1'b1) tmr <= 8'h01;
        else if (tmr == 8'h00)          tmr <= 8'h01;
        else                            tmr <= {tmr[6:0], tmr[7]};
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Micro-step table: control words for T3, T4, T5 and the number of
    // post-fetch steps (the last one restarts the ring).
    function automatic void prog(input logic [3:0] op, input logic c, input logic z,
                                 output int n, output logic [15:0] w3,
                                 output logic [15:0] w4, output logic [15:0] w5);
        n = 1; w3 = 16'h0000; w4 = 16'h0000; w5 = 16'h0000;
        case (op)
            4'd0:  begin n = 2; w3 = 16'h4800; w4 = 16'h1200; end
            4'd1:  begin n = 3; w3 = 16'h4800; w4 = 16'h1020; w5 = 16'h0281; end
            4'd2:  begin n = 3; w3 = 16'h4800; w4 = 16'h1020; w5 = 16'h02C1; end
            4'd3:  begin n = 2; w3 = 16'h4800; w4 = 16'h2100; end
            4'd4:  w3 = 16'h0A00;
            4'd5:  w3 = 16'h0802;
            4'd6:  w3 = c ? 16'h0802 : 16'h0000;
            4'd7:  w3 = z ? 16'h0802 : 16'h0000;
            4'd14: w3 = 16'h0110;
            4'd15: w3 = 16'h8000;
            default: w3 = 16'h0000;
        endcase
    endfunction

    // Model state and per-cycle predictions.
    logic        started = 1'b0;
    logic [3:0]  m_op;
    logic        m_stop, m_halted, m_fault;
    logic [3:0]  m_fcnt;
    logic [15:0] m_icnt;
    logic [15:0] e_ctrl;
    logic        e_rr, e_ret, e_flt, e_hlt, e_lat;
    logic [3:0]  e_opv;
`ifdef SEQ_SINGLE_STEP_EN
    logic        m_park;
    logic        e_pclr, e_smode, e_go;
`endif

    always @(negedge clk) begin
        if (started) begin
            int n, stp;
            logic idle;
            logic [3:0] opx;
            logic [15:0] w3, w4, w5;
            e_ctrl = 16'h0; e_rr = 0; e_ret = 0; e_flt = 0; e_hlt = 0; e_lat = 0;
            e_opv = ir_opcode;
            idle = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
            idle    = m_park && (m_stop || t_state == 8'h00);
            e_pclr  = m_park && !m_stop && (t_state != 8'h00) && !m_halted;
            e_smode = step_mode;
            e_go    = step_go;
`endif
            if (reset) begin
                e_rr = 1'b1;
            end else if (!(m_halted || idle)) begin
                if ($countones(t_state) != 1 || t_state >= 8'h20) begin
                    e_rr = 1'b1; e_flt = 1'b1;
                end else begin
                    stp = 0;
                    for (int i = 0; i < 5; i++) if (t_state[i]) stp = i + 1;
                    if (stp == 1)      e_ctrl = 16'h4004;
                    else if (stp == 2) e_ctrl = 16'h1408;
                    else begin
                        opx = (stp == 3) ? ir_opcode : m_op;
                        e_lat = (stp == 3);
                        prog(opx, carry_flag, zero_flag, n, w3, w4, w5);
                        if (stp - 2 > n) e_rr = 1'b1;
                        else begin
                            e_ctrl = (stp == 3) ? w3 : (stp == 4) ? w4 : w5;
                            if (stp - 2 == n) begin
                                e_rr = 1'b1; e_ret = 1'b1; e_hlt = (opx == 4'd15);
                            end
                        end
                    end
                end
            end
            chk("ctrl", ctrl, e_ctrl);
            chk("ring_restart", ring_restart, e_rr);
            chk("ring_stop", ring_stop, m_stop);
            chk("halted", halted, m_halted);
            chk("fault", fault, m_fault);
            chk("fault_cnt", fault_cnt, m_fcnt);
            chk("instr_cnt", instr_cnt, m_icnt);
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            started <= 1'b1;
            m_op <= 4'h0; m_stop <= 1'b0; m_halted <= 1'b0; m_fault <= 1'b0;
            m_fcnt <= 4'h0; m_icnt <= 16'h0;
`ifdef SEQ_SINGLE_STEP_EN
            m_park <= 1'b0;
`endif
        end else if (started) begin
            if (e_lat) m_op <= e_opv;
            if (e_ret) m_icnt <= m_icnt + 16'd1;
            if (e_flt) begin
                m_fault <= 1'b1;
                if (m_fcnt != 4'hF) m_fcnt <= m_fcnt + 4'd1;
            end
`ifdef SEQ_SINGLE_STEP_EN
            if (e_pclr) m_park <= 1'b0;
            if (e_ret && e_smode && !e_hlt) begin
                m_stop <= 1'b1; m_park <= 1'b1;
            end else if (e_go && m_stop && m_park && !m_halted) begin
                m_stop <= 1'b0;
            end
`endif
            if (e_hlt) begin m_halted <= 1'b1; m_stop <= 1'b1; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_t1(input string nm);
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            settle();
            if (t_state == 8'h01) seen = 1;
            else tick();
        end
        n_chk++;
        if (seen) n_pass++;
        else $display("FAIL %s: T1 not reached within budget, t_state=%0h", nm, t_state);
    endtask

    function automatic logic [7:0] bad_val();
        logic [7:0] one = 8'h01;
        int k = $urandom_range(0, 2);
        int a = $urandom_range(0, 7);
        int b = (a + 1 + $urandom_range(0, 6)) % 8;
        case (k)
            0:       return 8'h00;
            1:       return 8'h20 << $urandom_range(0, 2);
            default: return (one << a) | (one << b);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ic;
        int hcnt;
        // Reset state
        tick(); tick(); tick();
        settle();
        chk("rst_ctrl", ctrl, 16'h0000);
        chk("rst_restart", ring_restart, 1'b1);
        chk("rst_instr_cnt", instr_cnt, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        // LDI
        reset = 1'b0; settle();
        chk("ldi_t1", ctrl, 16'h4004);
        tick(); settle(); chk("ldi_t2", ctrl, 16'h1408);
        tick(); settle(); chk("ldi_t3", ctrl, 16'h0A00);
        chk("ldi_t3_restart", ring_restart, 1'b1);
        tick(); settle(); chk("ldi_retired", instr_cnt, 16'd1);
        // ADD, with IR changed during T4
        ir_opcode = 4'd1; carry_flag = 1'($urandom_range(0, 1));
        tick(); tick(); settle(); chk("add_t3", ctrl, 16'h4800);
        tick(); settle(); chk("add_t4", ctrl, 16'h1020);
        ir_opcode = 4'd0;
        tick(); settle(); chk("add_t5", ctrl, 16'h0281);
        chk("add_t5_restart", ring_restart, 1'b1);
        tick();
        // JC not taken / taken
        ir_opcode = 4'd6; carry_flag = 1'b0;
        tick(); tick(); settle();
        chk("jc_nc", ctrl, 16'h0000);
        chk("jc_nc_restart", ring_restart, 1'b1);
        tick(); carry_flag = 1'b1;
        tick(); tick(); settle(); chk("jc_c", ctrl, 16'h0802);
        tick();
        // HLT
        ir_opcode = 4'd15;
        tick(); tick(); settle(); chk("hlt_t3", ctrl, 16'h8000);
        tick(); settle();
        chk("hlt_halted", halted, 1'b1);
        chk("hlt_stop", ring_stop, 1'b1);
        force_en = 1'b1; force_val = 8'h00;
        for (int i = 0; i < 20; i++) tick();
        settle();
        chk("hlt_no_fault", fault, 1'b0);
        chk("hlt_ctrl0", ctrl, 16'h0000);
        force_en = 1'b0;
        // Fault injection
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        ir_opcode = 4'd4;
        settle(); ic = instr_cnt;
        force_en = 1'b1; force_val = 8'h05; settle();
        chk("flt05_ctrl", ctrl, 16'h0000); chk("flt05_rr", ring_restart, 1'b1);
        tick(); force_val = 8'h20; settle();
        chk("flt20_ctrl", ctrl, 16'h0000); chk("flt20_rr", ring_restart, 1'b1);
        tick(); force_val = 8'h00; settle();
        chk("flt00_ctrl", ctrl, 16'h0000); chk("flt00_rr", ring_restart, 1'b1);
        tick(); force_en = 1'b0; settle();
        chk("flt_sticky", fault, 1'b1);
        chk("flt_cnt3", fault_cnt, 4'd3);
        chk("flt_instr_hold", instr_cnt, ic);
        force_en = 1'b1; force_val = 8'h80;
        for (int i = 0; i < 20; i++) tick();
        force_en = 1'b0; settle();
        chk("flt_cnt_sat", fault_cnt, 4'hF);
`ifdef SEQ_SINGLE_STEP_EN
        // Single step
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        step_mode = 1'b1; ir_opcode = 4'd8;
        for (int i = 0; i < 10 && ring_stop !== 1'b1; i++) tick();
        settle(); chk("ss_paused", ring_stop, 1'b1);
        ic = instr_cnt;
        for (int i = 0; i < 10; i++) tick();
        settle();
        chk("ss_no_fault", fault, 1'b0);
        chk("ss_idle_rr", ring_restart, 1'b0);
        step_go = 1'b1; tick(); step_go = 1'b0; settle();
        chk("ss_released", ring_stop, 1'b0);
        wait_t1("ss_t1");
        tick(); tick(); tick(); settle();
        chk("ss_retired", instr_cnt, ic + 16'd1);
        chk("ss_repaused", ring_stop, 1'b1);
        step_mode = 1'b0;
`endif
        // Randomised operation
        reset = 1'b1; tick(); reset = 1'b0;
        hcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            ir_opcode  = 4'($urandom_range(0, 15));
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag  = 1'($urandom_range(0, 1));
            force_en   = ($urandom_range(0, 19) == 0);
            force_val  = bad_val();
`ifdef SEQ_SINGLE_STEP_EN
            if ($urandom_range(0, 29) == 0) step_mode = ~step_mode;
            step_go = ($urandom_range(0, 5) == 0);
`endif
            hcnt = m_halted ? hcnt + 1 : 0;
            reset = (hcnt > 4) || ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; force_en = 1'b0;
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ring_step_decoder.md
Name: ring_step_decoder

Overview:
- Consumer end of the one-hot T-state ring timer.
- Turns the timer's 8-bit one-hot step and the instruction register's opcode into the 16-bit datapath control word.
- Drives the timer's reset (restart) and stop inputs back to end each instruction early, halt the machine, and recover from corrupted ring states.
- Keeps an instruction retire counter and a fault counter for debug.

Parameters:
CNT_W, 16, width of the retired-instruction counter (wraps).
FAULT_W, 4, width of the fault counter (saturates).

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
t_state  in  8  one-hot step from timer; bit0=T1 … bit7=T8; 0 while timer is stopped
ir_opcode  in  4  upper nibble of the instruction register
carry_flag  in  1  ALU carry flag register
zero_flag  in  1  ALU zero flag register
ctrl  out  16  control word: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI
ring_restart  out  1  to timer reset; combinational; timer reloads T1 on the next edge
ring_stop  out  1  to timer stop; registered
halted  out  1  HLT executed; sticky until reset
fault  out  1  sticky; illegal ring state seen
fault_cnt  out  FAULT_W  saturating count of fault events
instr_cnt  out  CNT_W  retired instructions

Behaviour:
Reset values:
- ctrl=0, ring_stop=0, halted=0, fault=0, fault_cnt=0, instr_cnt=0, op_q=0.
- ring_restart is 1 during reset.

Fetch, for every opcode:
- T1: CO|MI.
- T2: RO|II|CE.

Opcode handling:
- T3 decodes ir_opcode directly.
- On the T3 edge, ir_opcode is latched into op_q; T4 and T5 decode op_q.
- IR changes after T3 have no effect on the current instruction.

Micro-steps (last step listed asserts ring_restart):
- 0 LDA: T3 IO|MI; T4 RO|AI (last).
- 1 ADD: T3 IO|MI; T4 RO|BI; T5 EO|AI|FI (last).
- 2 SUB: same as ADD, with SU also set in T5.
- 3 STA: T3 IO|MI; T4 AO|RI (last).
- 4 LDI: T3 IO|AI (last).
- 5 JMP: T3 IO|J (last).
- 6 JC: T3 IO|J if carry_flag=1, else 0 (last).
- 7 JZ: T3 IO|J if zero_flag=1, else 0 (last).
- 14 OUT: T3 AO|OI (last).
- 15 HLT: T3 HLT (last).
- All other opcodes are NOP: T3 ctrl=0 (last).

Retire and halt:
- instr_cnt increments on every clock where ring_restart is asserted from a legal last step. It wraps at 2^CNT_W.
- HLT at T3 sets halted and ring_stop on that edge. The HLT instruction counts as retired.
- While halted:
  - ctrl=0 and ring_restart=0.
  - t_state is ignored and is not a fault.
  - Only reset clears halted.

Faults (only checked when not halted):
- A fault is either of:
  - t_state not one-hot, including 0;
  - t_state in T6..T8, meaning a restart was missed.
- On a fault cycle:
  - ctrl=0.
  - ring_restart=1.
  - fault is set.
  - fault_cnt increments, saturating at all-ones.
  - instr_cnt does not increment.
- A fault that persists N consecutive cycles counts N events.

Simultaneous events:
- reset dominates all.
- A fault in the same cycle as a decoded HLT cannot happen, because a HLT decode requires a legal T3.

Optional Feature:
SEQ_SINGLE_STEP_EN:
- Defined: adds inputs step_mode (1 bit) and step_go (1 bit).
  - With step_mode=1, the retiring clock also sets ring_stop=1 (paused), so the timer parks at 0.
  - While paused: t_state=0 is legal, ctrl=0, ring_restart=0.
  - A step_go pulse clears ring_stop on its edge. The timer then advances 0→T1 and the next instruction runs to completion.
  - A step_go arriving while not paused is ignored.
  - Reset clears the paused state.
- Undefined: ports absent; behaviour as above.

Test Plan:
- Reset, then run the ring with ir_opcode=4 (LDI) → T1 ctrl=0x4004, T2 0x1408, T3 0x0A00 with ring_restart=1; instr_cnt=1 after the T3 edge.
- ADD with carry irrelevant → T3 0x4800, T4 0x1020, T5 0x0281 with restart; change ir_opcode to 0 during T4 → T5 word unchanged.
- JC with carry_flag=0 → T3 ctrl=0 and restart; repeat with carry_flag=1 → ctrl=0x0802.
- HLT at T3 → ctrl=0x8000; next cycle halted=1 and ring_stop=1; t_state=0 for 20 cycles → fault stays 0, ctrl=0.
- Force t_state=0x05, then 0x20, then 0x00 over three non-halted cycles → each cycle ctrl=0 and ring_restart=1; fault=1, fault_cnt=3, instr_cnt unchanged. Drive 20 more faults → fault_cnt holds 15.
- (SEQ_SINGLE_STEP_EN) step_mode=1, NOP retires → ring_stop=1; hold 10 cycles → no fault; pulse step_go → ring_stop=0 next edge, T1 follows, instr_cnt increments after T3.
